// File: rtl/vcu_mailbox.sv
// vcu_mailbox: producer/consumer register mailbox with per-channel credit-counted FIFOs
// Ports: clk, rst_n (async active-low); p_reg_* producer register port (control, data, rdata);
//        c_reg_* consumer register port; ch_empty/ch_full/ch_prog_full per-channel flags;
//        c_irq registered consumer interrupt.
module vcu_mailbox #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int NUM_CH    = 2,
  parameter int PROG_FULL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       p_reg_control,
  input  logic              p_reg_control_we,
  input  logic [31:0]       p_reg_wdata,
  input  logic              p_reg_wdata_we,
  output logic [31:0]       p_reg_rdata,
  input  logic [31:0]       c_reg_control,
  input  logic              c_reg_control_we,
  input  logic [31:0]       c_reg_wdata,
  input  logic              c_reg_wdata_we,
  output logic [31:0]       c_reg_rdata,
  output logic [NUM_CH-1:0] ch_empty,
  output logic [NUM_CH-1:0] ch_full,
  output logic [NUM_CH-1:0] ch_prog_full,
  output logic              c_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [5:0] p_ctrl, c_ctrl, p_sel, c_sel;
  logic [1:0] p_ch, c_ch;
  logic [3:0] p_idx, c_idx;
  logic p_ok, c_ok, p_push, c_pop, c_ne;
  logic [NUM_CH-1:0] p_hit, c_hit, push_ok, pop_ok, irq_mask;
  logic [2:0] p_status, c_status, p_clr, c_clr;
  logic [CW-1:0] cnt [NUM_CH];
  logic [AW-1:0] wp [NUM_CH];
  logic [AW-1:0] rp [NUM_CH];
  logic [WIDTH-1:0] mem [NUM_CH][DEPTH];
  logic [CW-1:0] p_credit;
  logic [WIDTH-1:0] c_head;
  logic unused;
  // a control write takes effect in the same cycle it is written, so strobes and
  // reads decode the incoming control value while its write strobe is high
  assign p_sel = p_reg_control_we ? p_reg_control[5:0] : p_ctrl;
  assign c_sel = c_reg_control_we ? c_reg_control[5:0] : c_ctrl;
  assign p_ch = p_sel[5:4];
  assign c_ch = c_sel[5:4];
  assign p_idx = p_sel[3:0];
  assign c_idx = c_sel[3:0];
  assign p_ok = int'(p_ch) < NUM_CH;
  assign c_ok = int'(c_ch) < NUM_CH;
  assign p_push = p_reg_wdata_we && p_idx == 4'd8;
  assign c_pop = c_reg_control_we && c_idx == 4'd5;
  assign p_clr = (p_reg_wdata_we && p_idx == 4'd2) ? p_reg_wdata[2:0] : 3'b000;
  assign c_clr = (c_reg_wdata_we && c_idx == 4'd2) ? c_reg_wdata[2:0] : 3'b000;
  assign unused = ^{p_reg_control[31:6], c_reg_control[31:6], p_reg_wdata, c_reg_wdata};
  always_comb begin
    p_hit = '0;
    c_hit = '0;
    ch_empty = '0;
    ch_full = '0;
    ch_prog_full = '0;
    p_credit = '0;
    c_ne = 1'b0;
    c_head = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      p_hit[i] = p_push && p_ch == 2'(i);
      c_hit[i] = c_pop && c_ch == 2'(i);
      ch_empty[i] = cnt[i] == '0;
      ch_full[i] = cnt[i] == CW'(DEPTH);
      ch_prog_full[i] = cnt[i] >= CW'(PROG_FULL);
      if (p_ch == 2'(i)) p_credit = CW'(DEPTH) - cnt[i];
      if (c_ch == 2'(i)) begin
        c_ne = cnt[i] != '0;
        c_head = (cnt[i] != '0) ? mem[i][rp[i]] : '0;
      end
    end
  end
  // both sides judge against pre-edge occupancy, so a full-channel push and an
  // empty-channel pop are rejected even when the other side acts in the same cycle
  assign push_ok = p_hit & ~ch_full;
  assign pop_ok = c_hit & ~ch_empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_ctrl <= '0;
      c_ctrl <= '0;
      p_status <= '0;
      c_status <= '0;
      irq_mask <= '0;
      c_irq <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      if (p_reg_control_we) p_ctrl <= p_reg_control[5:0];
      if (c_reg_control_we) c_ctrl <= c_reg_control[5:0];
      p_status <= (p_status & ~p_clr) | {p_push && !p_ok, 1'b0, |(p_hit & ch_full)};
      c_status <= (c_status & ~c_clr) | {c_pop && !c_ok, |(c_hit & ch_empty), 1'b0};
      if (c_reg_wdata_we && c_idx == 4'd6) irq_mask <= c_reg_wdata[NUM_CH-1:0];
      c_irq <= |(~ch_empty & irq_mask) || |c_status;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt[i] + CW'(push_ok[i]) - CW'(pop_ok[i]);
        if (push_ok[i]) wp[i] <= wp[i] + 1'b1;
        if (pop_ok[i]) rp[i] <= rp[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (push_ok[i]) mem[i][wp[i]] <= p_reg_wdata[WIDTH-1:0];
  end
  assign p_reg_rdata = !p_ok ? 32'h0 :
                       p_idx == 4'd4 ? 32'(p_credit) :
                       p_idx == 4'd2 ? {29'h0, p_status} : 32'h0;
  assign c_reg_rdata = !c_ok ? 32'h0 :
                       c_idx == 4'd3 ? {31'h0, c_ne} :
                       c_idx == 4'd9 ? 32'(c_head) :
                       c_idx == 4'd2 ? {29'h0, c_status} :
                       c_idx == 4'd6 ? 32'(irq_mask) : 32'h0;
endmodule

// File: tb/tb_vcu_mailbox.sv
// tb_vcu_mailbox: directed self-checking bench for vcu_mailbox (default parameters)
module tb_vcu_mailbox;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] p_reg_control = '0, p_reg_wdata = '0, c_reg_control = '0, c_reg_wdata = '0;
  logic p_reg_control_we = 1'b0, p_reg_wdata_we = 1'b0, c_reg_control_we = 1'b0, c_reg_wdata_we = 1'b0;
  logic [31:0] p_reg_rdata, c_reg_rdata;
  logic [1:0] ch_empty, ch_full, ch_prog_full;
  logic c_irq;
  int checks = 0;
  int errors = 0;

  vcu_mailbox dut (
    .clk(clk), .rst_n(rst_n),
    .p_reg_control(p_reg_control), .p_reg_control_we(p_reg_control_we),
    .p_reg_wdata(p_reg_wdata), .p_reg_wdata_we(p_reg_wdata_we), .p_reg_rdata(p_reg_rdata),
    .c_reg_control(c_reg_control), .c_reg_control_we(c_reg_control_we),
    .c_reg_wdata(c_reg_wdata), .c_reg_wdata_we(c_reg_wdata_we), .c_reg_rdata(c_reg_rdata),
    .ch_empty(ch_empty), .ch_full(ch_full), .ch_prog_full(ch_prog_full), .c_irq(c_irq)
  );

  always #5 clk = ~clk;

  task automatic p_ctrl_wr(input logic [3:0] idx, input logic [1:0] ch);
    @(negedge clk);
    p_reg_control = {26'h0, ch, idx};
    p_reg_control_we = 1'b1;
    @(posedge clk);
    #1 p_reg_control_we = 1'b0;
  endtask

  task automatic p_data_wr(input logic [31:0] d);
    @(negedge clk);
    p_reg_wdata = d;
    p_reg_wdata_we = 1'b1;
    @(posedge clk);
    #1 p_reg_wdata_we = 1'b0;
  endtask

  task automatic c_ctrl_wr(input logic [3:0] idx, input logic [1:0] ch);
    @(negedge clk);
    c_reg_control = {26'h0, ch, idx};
    c_reg_control_we = 1'b1;
    @(posedge clk);
    #1 c_reg_control_we = 1'b0;
  endtask

  task automatic c_data_wr(input logic [31:0] d);
    @(negedge clk);
    c_reg_wdata = d;
    c_reg_wdata_we = 1'b1;
    @(posedge clk);
    #1 c_reg_wdata_we = 1'b0;
  endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] d);
    p_ctrl_wr(4'd8, ch);
    p_data_wr(d);
  endtask

  task automatic pop(input logic [1:0] ch);
    c_ctrl_wr(4'd5, ch);
  endtask

  // push (producer control already at index 8) and pop on the same edge
  task automatic push_pop(input logic [31:0] d, input logic [1:0] ch);
    @(negedge clk);
    p_reg_wdata = d;
    p_reg_wdata_we = 1'b1;
    c_reg_control = {26'h0, ch, 4'd5};
    c_reg_control_we = 1'b1;
    @(posedge clk);
    #1;
    p_reg_wdata_we = 1'b0;
    c_reg_control_we = 1'b0;
  endtask

  task automatic clear_status();
    p_ctrl_wr(4'd2, 2'd0);
    p_data_wr(32'h7);
    c_ctrl_wr(4'd2, 2'd0);
    c_data_wr(32'h7);
  endtask

  task automatic test_reset();
    checks++; if (ch_empty !== 2'b11) begin errors++; $display("FAIL reset_empty: got %b exp 11", ch_empty); end
    checks++; if (ch_full !== 2'b00) begin errors++; $display("FAIL reset_full: got %b exp 00", ch_full); end
    checks++; if (ch_prog_full !== 2'b00) begin errors++; $display("FAIL reset_prog_full: got %b exp 00", ch_prog_full); end
    checks++; if (c_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", c_irq); end
    p_ctrl_wr(4'd4, 2'd0);
    checks++; if (p_reg_rdata !== 32'd8) begin errors++; $display("FAIL reset_credit: got %h exp 8", p_reg_rdata); end
    c_ctrl_wr(4'd3, 2'd1);
    checks++; if (c_reg_rdata !== 32'd0) begin errors++; $display("FAIL reset_nonempty: got %h exp 0", c_reg_rdata); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      push(2'd0, 32'h10 + i);
      checks++; if (ch_prog_full[0] !== (i >= 3)) begin errors++; $display("FAIL fill_prog_full[%0d]: got %b exp %b", i, ch_prog_full[0], i >= 3); end
      checks++; if (ch_full[0] !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d]: got %b exp %b", i, ch_full[0], i == 7); end
    end
    p_ctrl_wr(4'd4, 2'd0);
    checks++; if (p_reg_rdata !== 32'd0) begin errors++; $display("FAIL fill_credit: got %h exp 0", p_reg_rdata); end
    push(2'd0, 32'h18);
    p_ctrl_wr(4'd2, 2'd0);
    checks++; if (p_reg_rdata !== 32'd1) begin errors++; $display("FAIL fill_overflow: got %h exp 1", p_reg_rdata); end
    p_ctrl_wr(4'd4, 2'd0);
    checks++; if (p_reg_rdata !== 32'd0) begin errors++; $display("FAIL fill_credit_after_drop: got %h exp 0", p_reg_rdata); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      c_ctrl_wr(4'd9, 2'd0);
      checks++; if (c_reg_rdata !== 32'h10 + i) begin errors++; $display("FAIL drain_data[%0d]: got %h exp %h", i, c_reg_rdata, 32'h10 + i); end
      pop(2'd0);
    end
    checks++; if (ch_empty[0] !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b exp 1", ch_empty[0]); end
    pop(2'd0);
    c_ctrl_wr(4'd2, 2'd0);
    checks++; if (c_reg_rdata !== 32'd2) begin errors++; $display("FAIL drain_underflow: got %h exp 2", c_reg_rdata); end
    p_ctrl_wr(4'd4, 2'd0);
    checks++; if (p_reg_rdata !== 32'd8) begin errors++; $display("FAIL drain_credit: got %h exp 8", p_reg_rdata); end
    c_data_wr(32'h7);
    checks++; if (c_reg_rdata !== 32'd0) begin errors++; $display("FAIL drain_c_w1c: got %h exp 0", c_reg_rdata); end
    p_ctrl_wr(4'd2, 2'd0);
    p_data_wr(32'h7);
    checks++; if (p_reg_rdata !== 32'd0) begin errors++; $display("FAIL drain_p_w1c: got %h exp 0", p_reg_rdata); end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 8; i++) push(2'd0, 32'h20 + i);
    push_pop(32'hAA, 2'd0);
    p_ctrl_wr(4'd2, 2'd0);
    checks++; if (p_reg_rdata !== 32'd1) begin errors++; $display("FAIL coll_full_overflow: got %h exp 1", p_reg_rdata); end
    p_ctrl_wr(4'd4, 2'd0);
    checks++; if (p_reg_rdata !== 32'd1) begin errors++; $display("FAIL coll_full_credit: got %h exp 1", p_reg_rdata); end
    c_ctrl_wr(4'd9, 2'd0);
    checks++; if (c_reg_rdata !== 32'h21) begin errors++; $display("FAIL coll_full_head: got %h exp 21", c_reg_rdata); end
    for (int i = 0; i < 7; i++) pop(2'd0);
    checks++; if (ch_empty[0] !== 1'b1) begin errors++; $display("FAIL coll_drained: got %b exp 1", ch_empty[0]); end
    p_ctrl_wr(4'd8, 2'd0);
    push_pop(32'h55, 2'd0);
    c_ctrl_wr(4'd2, 2'd0);
    checks++; if (c_reg_rdata !== 32'd2) begin errors++; $display("FAIL coll_empty_underflow: got %h exp 2", c_reg_rdata); end
    checks++; if (ch_empty[0] !== 1'b0) begin errors++; $display("FAIL coll_empty_occ: got %b exp 0", ch_empty[0]); end
    c_ctrl_wr(4'd3, 2'd0);
    checks++; if (c_reg_rdata !== 32'd1) begin errors++; $display("FAIL coll_nonempty: got %h exp 1", c_reg_rdata); end
    c_ctrl_wr(4'd9, 2'd0);
    checks++; if (c_reg_rdata !== 32'h55) begin errors++; $display("FAIL coll_empty_head: got %h exp 55", c_reg_rdata); end
    pop(2'd0);
    clear_status();
  endtask

  task automatic test_bad_channel();
    push(2'd3, 32'h99);
    checks++; if (ch_empty !== 2'b11) begin errors++; $display("FAIL bad_no_push: got %b exp 11", ch_empty); end
    p_ctrl_wr(4'd2, 2'd3);
    checks++; if (p_reg_rdata !== 32'd0) begin errors++; $display("FAIL bad_rdata_zero: got %h exp 0", p_reg_rdata); end
    p_ctrl_wr(4'd2, 2'd0);
    checks++; if (p_reg_rdata !== 32'd4) begin errors++; $display("FAIL bad_p_status: got %h exp 4", p_reg_rdata); end
    pop(2'd2);
    c_ctrl_wr(4'd2, 2'd0);
    checks++; if (c_reg_rdata !== 32'd4) begin errors++; $display("FAIL bad_c_status: got %h exp 4", c_reg_rdata); end
    clear_status();
  endtask

  task automatic test_irq();
    c_ctrl_wr(4'd6, 2'd0);
    c_data_wr(32'h2);
    checks++; if (c_reg_rdata !== 32'd2) begin errors++; $display("FAIL irq_mask_rd: got %h exp 2", c_reg_rdata); end
    push(2'd0, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (c_irq !== 1'b0) begin errors++; $display("FAIL irq_ch0_masked: got %b exp 0", c_irq); end
    pop(2'd0);
    push(2'd1, 32'h77);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (c_irq !== 1'b1) begin errors++; $display("FAIL irq_ch1_set: got %b exp 1", c_irq); end
    pop(2'd1);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (c_irq !== 1'b0) begin errors++; $display("FAIL irq_ch1_clr: got %b exp 0", c_irq); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push(2'd1, 32'h30 + i);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (c_irq !== 1'b1) begin errors++; $display("FAIL rstmid_pre_irq: got %b exp 1", c_irq); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (ch_empty !== 2'b11) begin errors++; $display("FAIL rstmid_empty: got %b exp 11", ch_empty); end
    checks++; if (c_irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b exp 0", c_irq); end
    checks++; if (ch_full !== 2'b00) begin errors++; $display("FAIL rstmid_full: got %b exp 00", ch_full); end
    #1 rst_n = 1'b1;
    c_ctrl_wr(4'd6, 2'd0);
    checks++; if (c_reg_rdata !== 32'd0) begin errors++; $display("FAIL rstmid_mask: got %h exp 0", c_reg_rdata); end
    c_ctrl_wr(4'd9, 2'd1);
    checks++; if (c_reg_rdata !== 32'd0) begin errors++; $display("FAIL rstmid_head: got %h exp 0", c_reg_rdata); end
    p_ctrl_wr(4'd4, 2'd1);
    checks++; if (p_reg_rdata !== 32'd8) begin errors++; $display("FAIL rstmid_credit: got %h exp 8", p_reg_rdata); end
  endtask

  task automatic test_wrap();
    logic [31:0] q[$];
    logic [31:0] exp_d;
    for (int i = 0; i < 5; i++) begin
      push(2'd0, 32'h100 + i);
      q.push_back(32'h100 + i);
    end
    for (int i = 0; i < 20; i++) begin
      c_ctrl_wr(4'd9, 2'd0);
      exp_d = q.pop_front();
      checks++; if (c_reg_rdata !== exp_d) begin errors++; $display("FAIL wrap_data[%0d]: got %h exp %h", i, c_reg_rdata, exp_d); end
      pop(2'd0);
      push(2'd0, 32'h200 + i);
      q.push_back(32'h200 + i);
    end
    checks++; if (ch_empty[1] !== 1'b1) begin errors++; $display("FAIL wrap_ch1_untouched: got %b exp 1", ch_empty[1]); end
    while (q.size() > 0) begin
      c_ctrl_wr(4'd9, 2'd0);
      exp_d = q.pop_front();
      checks++; if (c_reg_rdata !== exp_d) begin errors++; $display("FAIL wrap_tail: got %h exp %h", c_reg_rdata, exp_d); end
      pop(2'd0);
    end
    checks++; if (ch_empty !== 2'b11) begin errors++; $display("FAIL wrap_empty: got %b exp 11", ch_empty); end
    p_ctrl_wr(4'd4, 2'd0);
    checks++; if (p_reg_rdata !== 32'd8) begin errors++; $display("FAIL wrap_credit: got %h exp 8", p_reg_rdata); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_collision();
    test_bad_channel();
    test_irq();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vcu_mailbox.md
VCU_MAILBOX -- requirements
Module: vcu_mailbox

Interface
REQ-001 Parameter WIDTH, default 32: message data width, 1..32.
REQ-002 Parameter DEPTH, default 8: entries per channel FIFO, power of two, >=2.
REQ-003 Parameter NUM_CH, default 2: channel count, 1..4; CH_W = 2 bits, field control[5:4].
REQ-004 Parameter PROG_FULL, default 4: per-channel programmable-full threshold, 1..DEPTH.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 p_reg_control  in  32  producer control register; [3:0] register index, [5:4] channel.
REQ-009 p_reg_control_we  in  1  producer control-register write strobe.
REQ-010 p_reg_wdata  in  32  producer write data; [WIDTH-1:0] is the message.
REQ-011 p_reg_wdata_we  in  1  producer data write strobe.
REQ-012 p_reg_rdata  out  32  producer read data, combinational.
REQ-013 c_reg_control, c_reg_control_we, c_reg_wdata, c_reg_wdata_we  in  32/1/32/1  consumer-side equivalents.
REQ-014 c_reg_rdata  out  32  consumer read data, combinational.
REQ-015 ch_empty, ch_full, ch_prog_full  out  NUM_CH each  per-channel flags.
REQ-016 c_irq  out  1  registered consumer interrupt.

Function
REQ-017 Each channel SHALL hold a FIFO of DEPTH x WIDTH and a credit counter; credit = DEPTH - occupancy; credit width clog2(DEPTH+1).
REQ-018 Push: p_reg_wdata_we with p index 8 SHALL push p_reg_wdata[WIDTH-1:0] to the selected channel iff its pre-edge credit > 0; the channel's credit decrements.
REQ-019 Push at credit 0 SHALL be dropped, leaving FIFO and credit unchanged, and SHALL set sticky p_status[0] (overflow).
REQ-020 Pop: c_reg_control_we with c index 5 SHALL pop the selected channel iff its pre-edge occupancy > 0; credit increments.
REQ-021 Pop on an empty channel SHALL be ignored and SHALL set sticky c_status[1] (underflow).
REQ-022 Push and pop on the same channel in the same cycle SHALL both be judged on pre-edge state; if both are accepted, credit and occupancy are unchanged.
REQ-023 A channel field >= NUM_CH SHALL make a push or pop a no-op, SHALL set sticky bit[2] (bad channel) on that side's status, and SHALL return rdata 0.
REQ-024 Producer reads: index 4 -> {28'h0, credit} zero-extended; index 2 -> {29'h0, p_status}; any other index -> 0.
REQ-025 Consumer reads: index 3 -> {31'h0, ~empty}; index 9 -> head entry zero-extended (first-word-fall-through; 0 when empty); index 2 -> {29'h0, c_status}; index 6 -> {28'h0, irq_mask}; any other index -> 0.
REQ-026 A pushed word SHALL be visible at consumer index 9, and ~empty SHALL be 1, in the cycle after the push edge.
REQ-027 A wdata_we at index 2 SHALL clear that side's status bits where wdata is 1 (write-1-to-clear); a set on the same edge SHALL win over the clear.
REQ-028 A c_reg_wdata_we at index 6 SHALL load irq_mask[NUM_CH-1:0] from c_reg_wdata.
REQ-029 c_irq SHALL be registered: next value = OR over channels of (~empty & irq_mask) OR (|c_status).
REQ-030 ch_full[i] SHALL equal (credit==0); ch_prog_full[i] SHALL equal (occupancy >= PROG_FULL); ch_empty[i] SHALL equal (occupancy==0).
REQ-031 FIFO pointers SHALL wrap modulo DEPTH without loss across repeated fill and drain.
REQ-032 Channels SHALL be independent; activity on one channel SHALL not alter another channel's state.

Reset
REQ-033 On rst_n low, immediately and independent of clk: all credits = DEPTH, FIFOs empty, status = 0, irq_mask = 0, c_irq = 0, ch_empty = all 1, ch_full = 0, ch_prog_full = 0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight messages; no push or pop SHALL take effect on the edge where rst_n is low.
REQ-035 FIFO data storage SHALL not require reset.

Verification
REQ-036 Push 8 words 0x10..0x17 to ch0 (DEPTH=8) -> credit 8->0, ch_prog_full[0] set after the 4th push, ch_full[0]=1; 9th push dropped with p_status=1.
REQ-037 Pop ch0 8 times reading index 9 -> data 0x10..0x17 in order; a 9th pop sets c_status bit1, credit returns to 8.
REQ-038 ch0 full, same-cycle push 0xAA and pop -> push rejected, overflow set, credit becomes 1; ch0 empty, same-cycle push and pop -> pop ignored, underflow set, occupancy becomes 1.
REQ-039 irq_mask=2'b10, push to ch1 -> c_irq=1 two cycles after the push edge; pop ch1 -> c_irq=0 after drain; a push to ch0 alone leaves c_irq=0.
REQ-040 Push 3 words to ch1, then pulse rst_n low between edges -> all outputs return to reset values immediately; 20 push/pop cycles with wrap -> no data loss, in-order delivery.
